// File: rtl/alu_16bit.sv
// alu_16bit: registered 16-bit ALU (and/or/add/sub/signed-amount shift/slt) with unsigned A<B flag
module alu_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] R,
  output logic             AltB
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH-1:0] w_mag, w_shift, w_res;
  logic             w_lt, w_big;
  logic [WIDTH-1:0] r_r;
  logic             r_altb;
  // negative B shifts right by its magnitude; any magnitude >= WIDTH (incl. the most negative B) clears the result
  always_comb begin
    w_lt    = A < B;
    w_mag   = B[WIDTH-1] ? (~B + 1'b1) : B;
    w_big   = |(w_mag >> SW);
    w_shift = w_big ? '0 : B[WIDTH-1] ? (A >> w_mag[SW-1:0]) : (A << w_mag[SW-1:0]);
    w_res   = op == 3'd0 ? (A & B) :
              op == 3'd1 ? (A | B) :
              op == 3'd2 ? (A + B) :
              op == 3'd3 ? (A - B) :
              op == 3'd4 ? w_shift :
              op == 3'd5 ? {{(WIDTH-1){1'b0}}, w_lt} : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r    <= '0;
      r_altb <= 1'b0;
    end else begin
      r_r    <= w_res;
      r_altb <= w_lt;
    end
  end
  assign R    = r_r;
  assign AltB = r_altb;
endmodule

// File: tb/tb_alu_16bit.sv
// tb_alu_16bit: directed and swept checks of alu_16bit against a behavioural model via an expectation queue
module tb_alu_16bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic [2:0]  op = '0;
  logic [15:0] R;
  logic        AltB;
  int          checks = 0, errors = 0;
  logic [16:0] q[$];

  alu_16bit dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .op(op), .R(R), .AltB(AltB));

  always #5 clk = ~clk;

  function automatic logic [15:0] model_r(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o);
    int s;
    s = int'($signed(b));
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return 16'((32'(a) + 32'(b)) % 65536);
      3'd3: return 16'((32'(a) + 65536 - 32'(b)) % 65536);
      3'd4: begin
        if (s >= 0) return (s >= 16) ? 16'h0 : 16'((32'(a) << s) & 32'hFFFF);
        return (-s >= 16) ? 16'h0 : 16'(32'(a) >> (-s));
      end
      3'd5: return (int'(a) < int'(b)) ? 16'h1 : 16'h0;
      default: return 16'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [2:0] o);
    logic [16:0] e;
    @(negedge clk);
    A = a; B = b; op = o;
    q.push_back({(int'(a) < int'(b)) ? 1'b1 : 1'b0, model_r(a, b, o)});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, ".R"}, 32'(R), 32'(e[15:0]));
    check({tag, ".AltB"}, 32'(AltB), 32'(e[16]));
  endtask

  initial begin
    A = 16'h1234; B = 16'h00FF; op = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.R", 32'(R), 32'h0);
    check("reset.AltB", 32'(AltB), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rel_and", 16'h1234, 16'h00FF, 3'd0);
    check("rel_and.val", 32'(R), 32'h0034);
    step("and", 16'hFFF6, 16'h0003, 3'd0);
    check("and.val", 32'(R), 32'h0002);
    step("or", 16'hFFF6, 16'h0003, 3'd1);
    check("or.val", 32'(R), 32'hFFF7);
    step("add_wrap", 16'hFFFF, 16'h0001, 3'd2);
    check("add_wrap.val", 32'(R), 32'h0000);
    step("sub_wrap", 16'h0000, 16'h0001, 3'd3);
    check("sub_wrap.val", 32'(R), 32'hFFFF);
    step("add_neg", 16'h0005, 16'hFFF6, 3'd2);
    check("add_neg.val", 32'(R), 32'hFFFB);
    step("shl4", 16'h0003, 16'h0004, 3'd4);
    check("shl4.val", 32'(R), 32'h0030);
    step("shr1", 16'h8000, 16'hFFFF, 3'd4);
    check("shr1.val", 32'(R), 32'h4000);
    step("shr10", 16'hFFF6, 16'hFFF6, 3'd4);
    check("shr10.val", 32'(R), 32'h003F);
    step("shl16", 16'hFFFF, 16'h0010, 3'd4);
    check("shl16.val", 32'(R), 32'h0000);
    step("shr_min", 16'hFFFF, 16'h8000, 3'd4);
    check("shr_min.val", 32'(R), 32'h0000);
    step("sh0", 16'hA5C3, 16'h0000, 3'd4);
    check("sh0.val", 32'(R), 32'hA5C3);
    step("shl15", 16'h0003, 16'h000F, 3'd4);
    check("shl15.val", 32'(R), 32'h8000);
    step("shr15", 16'h8000, 16'hFFF1, 3'd4);
    check("shr15.val", 32'(R), 32'h0001);
    step("slt_lt", 16'h0003, 16'h0009, 3'd5);
    check("slt_lt.val", 32'({AltB, R}), 32'h10001);
    step("slt_uns", 16'hFFF6, 16'h0005, 3'd5);
    check("slt_uns.val", 32'({AltB, R}), 32'h00000);
    step("slt_eq", 16'h0007, 16'h0007, 3'd5);
    check("slt_eq.val", 32'(AltB), 32'h0);
    step("op6", 16'h1234, 16'h5678, 3'd6);
    check("op6.val", 32'({AltB, R}), 32'h10000);
    step("op7", 16'hFFFF, 16'hFFFF, 3'd7);
    check("op7.val", 32'(R), 32'h0000);
    step("mid", 16'hFFFF, 16'h0001, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.R", 32'(R), 32'h0);
    check("async_rst.AltB", 32'(AltB), 32'h0);
    @(posedge clk);
    #1;
    check("held_rst.R", 32'(R), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++)
      for (int j = 0; j < 20; j++)
        for (int o = 0; o < 8; o++)
          step("sweep", 16'hFFF6 + 16'(i), 16'hFFF6 + 16'(j), 3'(o));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
